// File: rtl/riscv_pipeline_top.sv
// riscv_pipeline_top: five-stage RV32I-subset core
// with a 512-word instruction ROM and 256-word data RAM.
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef struct packed {
    logic    reg_we;
    logic    mem_we;
    logic    mem_rd;
    logic    alu_imm;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    logic        reg_we;
    logic        mem_we;
    logic        mem_rd;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_we;
    logic [31:0] data;
    logic [4:0]  rd;
  } mem_wb_t;

endpackage

module riscv_pipeline_top
  import riscv_pkg::*;
#(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_ADDR_WIDTH      = 10,
  parameter int P_REG_ADDR_WIDTH  = 5,
  parameter int P_IMEM_ADDR_WIDTH = 9,
  parameter int P_DMEM_ADDR_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  output logic                    o_dmem_we,
  output logic [P_DATA_WIDTH-1:0] o_dmem_addr,
  output logic [P_DATA_WIDTH-1:0] o_dmem_wdata,
  output logic [P_DATA_WIDTH-1:0] o_if_id_pc,
  output logic [P_DATA_WIDTH-1:0] o_if_id_instr
);

  localparam int IW = P_IMEM_ADDR_WIDTH;
  localparam int MW = P_DMEM_ADDR_WIDTH;
  localparam int AW = P_ADDR_WIDTH;
  localparam int RN = 2 ** P_REG_ADDR_WIDTH;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam if_id_t IF_BUB = '{pc: 32'd0, instr: NOP};

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6f;

  logic [31:0] l_rom [2**IW];
  logic [31:0] l_ram [2**MW];
  logic [31:0] rf    [RN];

  logic [31:0] pc;
  if_id_t      if_id;
  id_ex_t      id_ex;
  id_ex_t      id_nxt;
  ex_mem_t     ex_mem;
  ex_mem_t     ex_nxt;
  mem_wb_t     mem_wb;
  mem_wb_t     wb_nxt;

  logic [31:0] ins;
  logic [6:0]  op;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        is_r;
  logic        is_i;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  ctrl_t       ctl;
  logic [31:0] imm;
  logic [31:0] rv1;
  logic [31:0] rv2;

  logic        stall;
  logic        take;
  logic        hold;
  logic [31:0] fa;
  logic [31:0] fb;
  logic [31:0] opb;
  logic [31:0] alu;
  logic [31:0] tgt;
  logic [31:0] rdata;
  logic [31:0] mem_res;

  assign ins   = if_id.instr;
  assign op    = ins[6:0];
  assign rd    = ins[11:7];
  assign f3    = ins[14:12];
  assign rs1   = ins[19:15];
  assign rs2   = ins[24:20];
  assign f7    = ins[31:25];
  assign is_r  = (op == OP_R);
  assign is_i  = (op == OP_I);

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25],
                  ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_j = {{11{ins[31]}}, ins[31],
                  ins[19:12], ins[20],
                  ins[30:21], 1'b0};

  // decode: unknown encodings leave all control at zero (NOP)
  always_comb begin
    ctl = '0;
    imm = '0;
    unique case (1'b1)
      is_r && f7 == 7'h00 && f3 == 3'b000: begin
        ctl.reg_we = 1'b1;
      end
      is_r && f7 == 7'h20 && f3 == 3'b000: begin
        ctl.reg_we = 1'b1;
        ctl.alu_op = ALU_SUB;
      end
      is_r && f7 == 7'h00 && f3 == 3'b111: begin
        ctl.reg_we = 1'b1;
        ctl.alu_op = ALU_AND;
      end
      is_r && f7 == 7'h00 && f3 == 3'b110: begin
        ctl.reg_we = 1'b1;
        ctl.alu_op = ALU_OR;
      end
      is_r && f7 == 7'h00 && f3 == 3'b010: begin
        ctl.reg_we = 1'b1;
        ctl.alu_op = ALU_SLT;
      end
      is_i && f3 == 3'b000: begin
        ctl.reg_we  = 1'b1;
        ctl.alu_imm = 1'b1;
        imm         = imm_i;
      end
      is_i && f3 == 3'b010: begin
        ctl.reg_we  = 1'b1;
        ctl.alu_imm = 1'b1;
        ctl.alu_op  = ALU_SLT;
        imm         = imm_i;
      end
      is_i && f3 == 3'b111: begin
        ctl.reg_we  = 1'b1;
        ctl.alu_imm = 1'b1;
        ctl.alu_op  = ALU_AND;
        imm         = imm_i;
      end
      is_i && f3 == 3'b110: begin
        ctl.reg_we  = 1'b1;
        ctl.alu_imm = 1'b1;
        ctl.alu_op  = ALU_OR;
        imm         = imm_i;
      end
      op == OP_LD && f3 == 3'b010: begin
        ctl.reg_we  = 1'b1;
        ctl.mem_rd  = 1'b1;
        ctl.alu_imm = 1'b1;
        imm         = imm_i;
      end
      op == OP_ST && f3 == 3'b010: begin
        ctl.mem_we  = 1'b1;
        ctl.alu_imm = 1'b1;
        imm         = imm_s;
      end
      op == OP_BR && f3 == 3'b000: begin
        ctl.branch = 1'b1;
        imm        = imm_b;
      end
      op == OP_JAL: begin
        ctl.reg_we = 1'b1;
        ctl.jump   = 1'b1;
        imm        = imm_j;
      end
      default: ;
    endcase
  end

  // register read with write-through from WB
  assign rv1 = (rs1 == 5'd0) ? 32'd0 :
               (mem_wb.reg_we && mem_wb.rd == rs1) ?
               mem_wb.data : rf[rs1];
  assign rv2 = (rs2 == 5'd0) ? 32'd0 :
               (mem_wb.reg_we && mem_wb.rd == rs2) ?
               mem_wb.data : rf[rs2];

  assign id_nxt = '{ctrl: ctl, pc: if_id.pc,
                    rs1_v: rv1, rs2_v: rv2,
                    imm: imm, rs1: rs1,
                    rs2: rs2, rd: rd};

  assign stall = id_ex.ctrl.mem_rd &&
                 id_ex.rd != 5'd0 &&
                 (id_ex.rd == rs1 || id_ex.rd == rs2);

  // MEM stage: combinational RAM read
  assign rdata   = l_ram[ex_mem.alu[AW-1:2]];
  assign mem_res = ex_mem.mem_rd ? rdata : ex_mem.alu;

  // EX operand forwarding: MEM beats WB beats register
  always_comb begin
    fa = id_ex.rs1_v;
    fb = id_ex.rs2_v;
    if (id_ex.rs1 != 5'd0 && ex_mem.reg_we &&
        ex_mem.rd == id_ex.rs1)
      fa = mem_res;
    else if (id_ex.rs1 != 5'd0 && mem_wb.reg_we &&
             mem_wb.rd == id_ex.rs1)
      fa = mem_wb.data;
    if (id_ex.rs2 != 5'd0 && ex_mem.reg_we &&
        ex_mem.rd == id_ex.rs2)
      fb = mem_res;
    else if (id_ex.rs2 != 5'd0 && mem_wb.reg_we &&
             mem_wb.rd == id_ex.rs2)
      fb = mem_wb.data;
  end

  assign opb = id_ex.ctrl.alu_imm ? id_ex.imm : fb;

  // ALU
  always_comb begin
    case (id_ex.ctrl.alu_op)
      ALU_SUB: alu = fa - opb;
      ALU_AND: alu = fa & opb;
      ALU_OR:  alu = fa | opb;
      ALU_SLT: alu = {31'd0,
                      $signed(fa) < $signed(opb)};
      default: alu = fa + opb;
    endcase
  end

  assign tgt  = id_ex.pc + id_ex.imm;
  assign take = id_ex.ctrl.jump ||
                (id_ex.ctrl.branch && fa == fb);
  assign hold = stall && !take;

  assign ex_nxt = '{reg_we: id_ex.ctrl.reg_we,
                    mem_we: id_ex.ctrl.mem_we,
                    mem_rd: id_ex.ctrl.mem_rd,
                    alu: id_ex.ctrl.jump ?
                         id_ex.pc + 32'd4 : alu,
                    wdata: fb,
                    rd: id_ex.rd};

  assign wb_nxt = '{reg_we: ex_mem.reg_we,
                    data: mem_res,
                    rd: ex_mem.rd};

  // pipeline registers; a redirect overrides a stall
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc     <= '0;
      if_id  <= IF_BUB;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      ex_mem <= ex_nxt;
      mem_wb <= wb_nxt;
      unique case (1'b1)
        take: begin
          pc    <= tgt;
          if_id <= IF_BUB;
          id_ex <= '0;
        end
        hold: begin
          id_ex <= '0;
        end
        default: begin
          pc    <= pc + 32'd4;
          if_id <= '{pc: pc,
                     instr: l_rom[pc[IW+1:2]]};
          id_ex <= id_nxt;
        end
      endcase
    end
  end

  // register file; x0 is never written
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < RN; i++)
        rf[i] <= '0;
    end else if (mem_wb.reg_we &&
                 mem_wb.rd != 5'd0) begin
      rf[mem_wb.rd] <= mem_wb.data;
    end
  end

  // data RAM write port; contents survive reset
  always_ff @(posedge i_clk) begin
    if (!i_rst && ex_mem.mem_we)
      l_ram[ex_mem.alu[AW-1:2]] <= ex_mem.wdata;
  end

  assign o_dmem_we     = ex_mem.mem_we;
  assign o_dmem_addr   = ex_mem.alu;
  assign o_dmem_wdata  = ex_mem.wdata;
  assign o_if_id_pc    = if_id.pc;
  assign o_if_id_instr = if_id.instr;

endmodule

// File: tb/tb_riscv_pipeline_top.sv
// tb_riscv_pipeline_top: directed programs for the
// pipelined core, checked against hand-derived values.
module tb_riscv_pipeline_top;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [31:0] o_if_id_pc;
  logic [31:0] o_if_id_instr;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] LOOP = 32'h0000_006f;

  int total = 0;
  int bad   = 0;
  int tick  = 0;
  int rel   = 0;
  int holds;
  int cc;

  logic [31:0] wa [$];
  logic [31:0] wd [$];
  int          wc [$];
  logic [31:0] prog [$];
  logic [31:0] tr_pc [64];
  logic [31:0] tr_in [64];

  riscv_pipeline_top dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_wdata (o_dmem_wdata),
    .o_if_id_pc   (o_if_id_pc),
    .o_if_id_instr(o_if_id_instr)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) tick++;

  // trace IF/ID and log memory writes per cycle
  always @(negedge i_clk) begin
    cc = tick - rel;
    if (cc >= 0 && cc < 64) begin
      tr_pc[cc] = o_if_id_pc;
      tr_in[cc] = o_if_id_instr;
    end
    if (!i_rst && o_dmem_we) begin
      wa.push_back(o_dmem_addr);
      wd.push_back(o_dmem_wdata);
      wc.push_back(cc);
    end
  end

  function automatic logic [31:0] e_r(
    input logic [6:0] f7, input int rd,
    input int rs1, input int rs2,
    input logic [2:0] f3);
    logic [4:0] a, b, c;
    a = rd[4:0]; b = rs1[4:0]; c = rs2[4:0];
    return {f7, c, b, f3, a, 7'h33};
  endfunction

  function automatic logic [31:0] e_i(
    input int rd, input int rs1, input int imm,
    input logic [2:0] f3, input logic [6:0] op);
    logic [31:0] v;
    logic [4:0]  a, b;
    v = imm; a = rd[4:0]; b = rs1[4:0];
    return {v[11:0], b, f3, a, op};
  endfunction

  function automatic logic [31:0] e_add(
    input int rd, input int a, input int b);
    return e_r(7'h00, rd, a, b, 3'b000);
  endfunction

  function automatic logic [31:0] e_sub(
    input int rd, input int a, input int b);
    return e_r(7'h20, rd, a, b, 3'b000);
  endfunction

  function automatic logic [31:0] e_and(
    input int rd, input int a, input int b);
    return e_r(7'h00, rd, a, b, 3'b111);
  endfunction

  function automatic logic [31:0] e_or(
    input int rd, input int a, input int b);
    return e_r(7'h00, rd, a, b, 3'b110);
  endfunction

  function automatic logic [31:0] e_slt(
    input int rd, input int a, input int b);
    return e_r(7'h00, rd, a, b, 3'b010);
  endfunction

  function automatic logic [31:0] e_addi(
    input int rd, input int a, input int imm);
    return e_i(rd, a, imm, 3'b000, 7'h13);
  endfunction

  function automatic logic [31:0] e_slti(
    input int rd, input int a, input int imm);
    return e_i(rd, a, imm, 3'b010, 7'h13);
  endfunction

  function automatic logic [31:0] e_andi(
    input int rd, input int a, input int imm);
    return e_i(rd, a, imm, 3'b111, 7'h13);
  endfunction

  function automatic logic [31:0] e_ori(
    input int rd, input int a, input int imm);
    return e_i(rd, a, imm, 3'b110, 7'h13);
  endfunction

  function automatic logic [31:0] e_lw(
    input int rd, input int a, input int imm);
    return e_i(rd, a, imm, 3'b010, 7'h03);
  endfunction

  function automatic logic [31:0] e_sw(
    input int rs2, input int rs1, input int imm);
    logic [31:0] v;
    logic [4:0]  a, b;
    v = imm; a = rs2[4:0]; b = rs1[4:0];
    return {v[11:5], a, b, 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] e_beq(
    input int rs1, input int rs2, input int imm);
    logic [31:0] v;
    logic [4:0]  a, b;
    v = imm; a = rs1[4:0]; b = rs2[4:0];
    return {v[12], v[10:5], b, a, 3'b000,
            v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] e_jal(
    input int rd, input int imm);
    logic [31:0] v;
    logic [4:0]  a;
    v = imm; a = rd[4:0];
    return {v[20], v[10:1], v[11], v[19:12],
            a, 7'h6f};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] at_a(input int k);
    return (k < wa.size()) ? wa[k] : 32'hdead_beef;
  endfunction

  function automatic logic [31:0] at_d(input int k);
    return (k < wd.size()) ? wd[k] : 32'hdead_beef;
  endfunction

  function automatic int at_c(input int k);
    return (k < wc.size()) ? wc[k] : -1;
  endfunction

  // reset, load program, release at cycle 0
  task automatic start();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    for (int i = 0; i < 512; i++)
      dut.l_rom[i] = NOP;
    foreach (prog[i])
      dut.l_rom[i] = prog[i];
    wa.delete(); wd.delete(); wc.delete();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    rel   = tick;
  endtask

  task automatic wait_wr(input string tag,
                         input int n,
                         input int budget);
    int c;
    c = 0;
    while (wa.size() < n && c < budget) begin
      @(negedge i_clk);
      c++;
    end
    total++;
    assert (wa.size() >= n) else begin
      bad++;
      $error("FAIL %s_timeout: got %0d want %0d",
             tag, wa.size(), n);
    end
    repeat (20) @(negedge i_clk);
    chk({tag, "_nwr"}, wa.size(), n);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_we", {31'd0, o_dmem_we}, 32'd0);
    chk("rst_addr", o_dmem_addr, 32'd0);
    chk("rst_wdata", o_dmem_wdata, 32'd0);
    chk("rst_pc", o_if_id_pc, 32'd0);
    chk("rst_instr", o_if_id_instr, NOP);

    // standard program: 7 @ 96 then 25 @ 100
    prog.delete();
    prog.push_back(e_addi(1, 0, 3));
    prog.push_back(e_addi(2, 0, 4));
    prog.push_back(e_add(3, 1, 2));
    prog.push_back(e_sw(3, 0, 96));
    prog.push_back(e_sub(4, 3, 1));
    prog.push_back(e_and(5, 3, 2));
    prog.push_back(e_or(6, 1, 2));
    prog.push_back(e_slt(7, 1, 2));
    prog.push_back(e_beq(7, 0, 8));
    prog.push_back(e_lw(8, 0, 96));
    prog.push_back(e_add(9, 8, 6));
    prog.push_back(e_beq(4, 5, 8));
    prog.push_back(e_sw(0, 0, 96));
    prog.push_back(e_add(10, 9, 8));
    prog.push_back(e_add(10, 10, 4));
    prog.push_back(e_jal(0, 8));
    prog.push_back(e_sw(0, 0, 100));
    prog.push_back(e_sw(10, 0, 100));
    prog.push_back(LOOP);
    start();
    wait_wr("std", 2, 5000);
    chk("std_a0", at_a(0), 32'd96);
    chk("std_d0", at_d(0), 32'd7);
    chk("std_a1", at_a(1), 32'd100);
    chk("std_d1", at_d(1), 32'd25);

    // back-to-back RAW, no stall
    prog.delete();
    prog.push_back(e_addi(1, 0, 5));
    prog.push_back(e_add(2, 1, 1));
    prog.push_back(e_sw(2, 0, 0));
    prog.push_back(LOOP);
    start();
    wait_wr("raw", 1, 100);
    chk("raw_a", at_a(0), 32'd0);
    chk("raw_d", at_d(0), 32'd10);
    chk("raw_cyc", at_c(0), 32'd5);

    // load-use: one stall cycle
    prog.delete();
    prog.push_back(e_addi(1, 0, 42));
    prog.push_back(e_sw(1, 0, 8));
    prog.push_back(e_lw(3, 0, 8));
    prog.push_back(e_addi(4, 3, 1));
    prog.push_back(e_sw(4, 0, 12));
    prog.push_back(LOOP);
    start();
    wait_wr("ldu", 2, 100);
    chk("ldu_a0", at_a(0), 32'd8);
    chk("ldu_d0", at_d(0), 32'd42);
    chk("ldu_a1", at_a(1), 32'd12);
    chk("ldu_d1", at_d(1), 32'd43);
    chk("ldu_cyc", at_c(1), 32'd8);
    holds = 0;
    for (int c = 2; c <= 8; c++)
      if (tr_pc[c] === tr_pc[c-1]) holds++;
    chk("ldu_holds", holds, 32'd1);
    chk("ldu_pc5", tr_pc[5], 32'h0c);
    chk("ldu_pc6", tr_pc[6], 32'h10);

    // taken beq flushes two addi x5
    prog.delete();
    prog.push_back(e_addi(5, 0, 1));
    prog.push_back(e_beq(0, 0, 12));
    prog.push_back(e_addi(5, 0, 2));
    prog.push_back(e_addi(5, 0, 3));
    prog.push_back(e_sw(5, 0, 16));
    prog.push_back(e_addi(6, 0, 9));
    prog.push_back(e_sw(6, 0, 24));
    prog.push_back(LOOP);
    start();
    wait_wr("beq", 2, 100);
    chk("beq_a0", at_a(0), 32'd16);
    chk("beq_d0", at_d(0), 32'd1);
    chk("beq_cyc", at_c(0), 32'd7);
    chk("beq_a1", at_a(1), 32'd24);
    chk("beq_d1", at_d(1), 32'd9);

    // jal at 0x10 links 0x14, skips one slot
    prog.delete();
    repeat (4) prog.push_back(NOP);
    prog.push_back(e_jal(1, 8));
    prog.push_back(e_addi(1, 0, 99));
    prog.push_back(e_sw(1, 0, 20));
    prog.push_back(LOOP);
    start();
    wait_wr("jal", 1, 100);
    chk("jal_a", at_a(0), 32'd20);
    chk("jal_d", at_d(0), 32'h14);
    chk("jal_cyc", at_c(0), 32'd10);

    // signed compares, logic immediates, NOP opcode
    prog.delete();
    prog.push_back(e_addi(1, 0, -5));
    prog.push_back(e_slti(2, 1, -4));
    prog.push_back(e_slt(3, 0, 1));
    prog.push_back(e_andi(4, 1, 32'h0f0));
    prog.push_back(e_ori(5, 1, 32'h00f));
    prog.push_back(e_sw(2, 0, 200));
    prog.push_back(e_sw(3, 0, 204));
    prog.push_back(e_sw(4, 0, 208));
    prog.push_back(e_sw(5, 0, 212));
    prog.push_back(32'h0000_1337);
    prog.push_back(e_sw(6, 0, 216));
    prog.push_back(LOOP);
    start();
    wait_wr("sgn", 5, 200);
    chk("sgn_slti", at_d(0), 32'd1);
    chk("sgn_slt", at_d(1), 32'd0);
    chk("sgn_andi", at_d(2), 32'h0000_00f0);
    chk("sgn_ori", at_d(3), 32'hffff_ffff);
    chk("sgn_lui", at_d(4), 32'd0);
    chk("sgn_a4", at_a(4), 32'd216);

    // x0 stays zero; mid-program reset restarts
    prog.delete();
    prog.push_back(e_addi(0, 0, 7));
    prog.push_back(e_sw(0, 0, 4));
    prog.push_back(e_addi(2, 0, 5));
    prog.push_back(e_sw(2, 0, 28));
    prog.push_back(LOOP);
    start();
    repeat (3) @(posedge i_clk);
    #1;
    chk("mid_pre_pc", o_if_id_pc, 32'h8);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("mid_rst_pc", o_if_id_pc, 32'd0);
    chk("mid_rst_in", o_if_id_instr, NOP);
    chk("mid_nowr", wa.size(), 32'd0);
    i_rst = 1'b0;
    rel   = tick;
    wait_wr("x0", 2, 100);
    chk("x0_pc1", tr_pc[1], 32'd0);
    chk("x0_in1", tr_in[1], e_addi(0, 0, 7));
    chk("x0_pc2", tr_pc[2], 32'd4);
    chk("x0_a0", at_a(0), 32'd4);
    chk("x0_d0", at_d(0), 32'd0);
    chk("x0_a1", at_a(1), 32'd28);
    chk("x0_d1", at_d(1), 32'd5);
    chk("ram_kept", dut.l_ram[3], 32'd43);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
